// File: rtl/layer_denorm.sv
// layer_denorm: rebuilds vector elements as x*scale + mean behind a one-deep output register.
// Optional macro LAYER_DENORM_SAT_EN clamps results to the unsigned output range instead of wrapping.
module layer_denorm #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [DATA_WIDTH+3:0]   cfg_mean,
  input  logic [DATA_WIDTH-1:0]   cfg_scale,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    done
);

  localparam int FW = 2*DATA_WIDTH + 6;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH+3:0] r_mean;
  logic [DATA_WIDTH-1:0] r_scale;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_is_last;
  logic signed [FW-1:0]  w_x;
  logic signed [FW-1:0]  w_scale;
  logic signed [FW-1:0]  w_mean;
  logic signed [FW-1:0]  w_full;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_unused_bits;

  assign cfg_ready = (r_state == S_IDLE);
  assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign w_is_last = (r_count == LAST_IDX);

  // Operands widened to the full result width so neither product nor sum can overflow.
  assign w_x     = $signed({{(FW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data});
  assign w_scale = $signed({{(FW-DATA_WIDTH){1'b0}}, r_scale});
  assign w_mean  = $signed({{(FW-DATA_WIDTH-4){1'b0}}, r_mean});
  assign w_full  = w_x * w_scale + w_mean;

`ifdef LAYER_DENORM_SAT_EN
  always_comb begin
    w_result = w_full[DATA_WIDTH-1:0];
    if (w_full[FW-1]) begin
      w_result = '0;
    end else if (|w_full[FW-2:DATA_WIDTH]) begin
      w_result = '1;
    end
  end
`else
  assign w_result = w_full[DATA_WIDTH-1:0];
`endif

  assign w_unused_bits = ^w_full[FW-1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_mean  <= '0;
      r_scale <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_mean  <= cfg_mean;
            r_scale <= cfg_scale;
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_push) begin
            if (w_is_last) begin
              r_count <= '0;
              r_state <= S_FLUSH;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // done is raised only once the final element has actually left.
          if (w_pop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_is_last;
      r_out_data  <= w_result;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule

// File: tb/tb_layer_denorm.sv
// Scoreboard bench for layer_denorm: expected elements queued on input handshake, compared on output pop.
`timescale 1ns/1ps
module tb_layer_denorm;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [W+3:0] cfg_mean = '0;
  logic [W-1:0] cfg_scale = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         cfg_ready, in_ready, out_valid, out_last, done;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  layer_denorm #(.N(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mean(cfg_mean), .cfg_scale(cfg_scale),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int timeouts = 0;
  int elem_idx = 0;
  bit pushed = 0;
  logic [W+3:0] cur_mean = '0;
  logic [W-1:0] cur_scale = '0;
  logic [W-1:0] exp_data[$];
  logic [W-1:0] act_data[$];
  bit exp_last[$];
  bit act_last[$];
  int push_cyc[$];
  int pop_cyc[$];

  function automatic logic [W-1:0] model(input logic [W+3:0] m, input logic [W-1:0] s,
                                         input logic [W-1:0] x);
    longint v;
    v = longint'($signed(x)) * longint'(s) + longint'(m);
`ifdef LAYER_DENORM_SAT_EN
    if (v < 0) v = 0;
    else if (v > (longint'(1) << W) - 1) v = (longint'(1) << W) - 1;
`endif
    return v[W-1:0];
  endfunction

  // One clock: record handshakes at the falling edge, then settle just past the rising edge.
  task automatic tick();
    @(negedge clk);
    pushed = 0;
    if (in_valid && in_ready && !rst) begin
      exp_data.push_back(model(cur_mean, cur_scale, in_data));
      exp_last.push_back(elem_idx == N - 1);
      elem_idx = (elem_idx == N - 1) ? 0 : elem_idx + 1;
      push_cyc.push_back(cyc);
      pushed = 1;
    end
    if (out_valid && out_ready && !rst) begin
      act_data.push_back(out_data);
      act_last.push_back(out_last);
      pop_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_sb();
    exp_data.delete(); act_data.delete(); exp_last.delete(); act_last.delete();
    push_cyc.delete(); pop_cyc.delete();
    done_cnt = 0; done_cyc = -1; timeouts = 0;
  endtask

  task automatic do_cfg(input logic [W+3:0] m, input logic [W-1:0] s);
    cfg_valid = 1'b1; cfg_mean = m; cfg_scale = s;
    tick();
    cfg_valid = 1'b0;
    cur_mean = m; cur_scale = s; elem_idx = 0;
  endtask

  task automatic send_elem(input logic [W-1:0] x);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = x;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pushed) begin ok = 1; break; end
    end
    if (!ok) timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b need 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %0d need 0", out_data); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b need 0", out_last); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b need 0", done); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b need 0", in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b need 1", cfg_ready); else n_pass++;
    $display("reset: out_valid=%b cfg_ready=%b", out_valid, cfg_ready);
  endtask

  task automatic test_basic();
    logic [W-1:0] want [4];
    logic [W-1:0] e, a;
    bit el, al;
    int i;
    want = '{8'd94, 8'd100, 8'd110, 8'd120};
    clear_sb();
    do_cfg(12'd100, 8'd2);
    out_ready = 1'b1;
    send_elem(8'hFD); send_elem(8'd0); send_elem(8'd5); send_elem(8'd10);
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (act_data.size() !== 4) $display("FAIL basic_count: got %0d need 4", act_data.size()); else n_pass++;
    n_checks++; if (timeouts !== 0) $display("FAIL basic_timeout: got %0d need 0", timeouts); else n_pass++;
    if (push_cyc.size() >= 1 && pop_cyc.size() >= 4) begin
      n_checks++; if (pop_cyc[0] - push_cyc[0] !== 1) $display("FAIL basic_latency: got %0d need 1", pop_cyc[0] - push_cyc[0]); else n_pass++;
      n_checks++; if (pop_cyc[3] - pop_cyc[0] !== 3) $display("FAIL basic_consecutive: got %0d need 3", pop_cyc[3] - pop_cyc[0]); else n_pass++;
      n_checks++; if (done_cyc !== pop_cyc[3] + 1) $display("FAIL basic_done_cycle: got %0d need %0d", done_cyc, pop_cyc[3] + 1); else n_pass++;
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d need 1", done_cnt); else n_pass++;
    i = 0;
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("basic elem %0d: out=%0d last=%0b expect=%0d last=%0b", i, a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL basic_elem%0d: got %0d/%0b need %0d/%0b", i, a, al, e, el); else n_pass++;
      n_checks++; if (a !== want[i]) $display("FAIL basic_const%0d: got %0d need %0d", i, a, want[i]); else n_pass++;
      i++;
    end
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL basic_idle_cfg_ready: got %b need 1", cfg_ready); else n_pass++;
  endtask

  task automatic test_range(input string name, input logic [W+3:0] m, input logic [W-1:0] s,
                            input logic [W-1:0] x, input logic [W-1:0] want_sat, input logic [W-1:0] want_wrap);
    logic [W-1:0] e, a, want;
    bit el, al;
`ifdef LAYER_DENORM_SAT_EN
    want = want_sat;
`else
    want = want_wrap;
`endif
    clear_sb();
    do_cfg(m, s);
    out_ready = 1'b1;
    send_elem(x); send_elem(8'd0); send_elem(8'd1); send_elem(8'd0);
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (act_data.size() !== 4) $display("FAIL %s_count: got %0d need 4", name, act_data.size()); else n_pass++;
    if (act_data.size() > 0) begin
      n_checks++; if (act_data[0] !== want) $display("FAIL %s_value: got %0d need %0d", name, act_data[0], want); else n_pass++;
    end
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("%s elem: out=%0d last=%0b expect=%0d last=%0b", name, a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL %s_elem: got %0d/%0b need %0d/%0b", name, a, al, e, el); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e, a, held;
    bit el, al;
    clear_sb();
    do_cfg(12'd10, 8'd3);
    out_ready = 1'b1;
    send_elem(8'd1); send_elem(8'd2);
    held = model(12'd10, 8'd3, 8'd2);
    out_ready = 1'b0; in_data = 8'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("stall %0d: in_ready=%b out_valid=%b out_data=%0d", k, in_ready, out_valid, out_data);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b need 0", k, in_ready); else n_pass++;
      n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, held, 1'b0})
        $display("FAIL bp_hold%0d: got v=%b d=%0d l=%b need v=1 d=%0d l=0", k, out_valid, out_data, out_last, held); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    send_elem(8'd3); send_elem(8'd4);
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (act_data.size() !== 4) $display("FAIL bp_count: got %0d need 4", act_data.size()); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL bp_done_count: got %0d need 1", done_cnt); else n_pass++;
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("bp elem: out=%0d last=%0b expect=%0d last=%0b", a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL bp_elem: got %0d/%0b need %0d/%0b", a, al, e, el); else n_pass++;
    end
  endtask

  task automatic test_busy_cfg();
    logic [W-1:0] e, a;
    bit el, al;
    clear_sb();
    do_cfg(12'd50, 8'd3);
    out_ready = 1'b1;
    send_elem(8'd1); send_elem(8'd2);
    cfg_valid = 1'b1; cfg_mean = 12'd7; cfg_scale = 8'd9;
    #1;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL busy_cfg_ready: got %b need 0", cfg_ready); else n_pass++;
    send_elem(8'd3); send_elem(8'hFF);
    cfg_valid = 1'b0; in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (act_data.size() !== 4) $display("FAIL busy_count: got %0d need 4", act_data.size()); else n_pass++;
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("busy elem: out=%0d last=%0b expect=%0d last=%0b", a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL busy_elem: got %0d/%0b need %0d/%0b", a, al, e, el); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e, a;
    bit el, al;
    clear_sb();
    do_cfg(12'd20, 8'd1);
    out_ready = 1'b1;
    send_elem(8'd5); send_elem(8'd6);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b need 0", out_valid); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL mrst_cfg_ready: got %b need 1", cfg_ready); else n_pass++;
    out_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (done_cnt !== 0) $display("FAIL mrst_no_done: got %0d need 0", done_cnt); else n_pass++;
    n_checks++; if (act_data.size() !== 1) $display("FAIL mrst_popped: got %0d need 1", act_data.size()); else n_pass++;
    if (act_data.size() > 0) begin
      n_checks++; if (act_data[0] !== 8'd25) $display("FAIL mrst_first: got %0d need 25", act_data[0]); else n_pass++;
    end
    clear_sb();
    do_cfg(12'd30, 8'd5);
    send_elem(8'd1); send_elem(8'd2); send_elem(8'hFE); send_elem(8'd4);
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (act_data.size() !== 4) $display("FAIL mrst_new_count: got %0d need 4", act_data.size()); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL mrst_new_done: got %0d need 1", done_cnt); else n_pass++;
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("mrst elem: out=%0d last=%0b expect=%0d last=%0b", a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL mrst_elem: got %0d/%0b need %0d/%0b", a, al, e, el); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, a;
    bit el, al;
    int sent, guard;
    clear_sb();
    for (int v = 0; v < 3; v++) begin
      out_ready = 1'b1;
      do_cfg(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
      sent = 0; guard = 0;
      in_valid = 1'b1; in_data = 8'($urandom_range(0, 255));
      while (sent < N && guard < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        guard++;
        if (pushed) begin
          sent++;
          in_data = 8'($urandom_range(0, 255));
        end
      end
      if (sent < N) timeouts++;
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (done_cnt < v + 1 && guard < 20) begin tick(); guard++; end
    end
    n_checks++; if (timeouts !== 0) $display("FAIL b2b_timeout: got %0d need 0", timeouts); else n_pass++;
    n_checks++; if (done_cnt !== 3) $display("FAIL b2b_done_count: got %0d need 3", done_cnt); else n_pass++;
    n_checks++; if (act_data.size() !== 3 * N) $display("FAIL b2b_count: got %0d need %0d", act_data.size(), 3 * N); else n_pass++;
    while (exp_data.size() > 0 && act_data.size() > 0) begin
      e = exp_data.pop_front(); a = act_data.pop_front(); el = exp_last.pop_front(); al = act_last.pop_front();
      $display("b2b elem: out=%0d last=%0b expect=%0d last=%0b", a, al, e, el);
      n_checks++; if ({a, al} !== {e, el}) $display("FAIL b2b_elem: got %0d/%0b need %0d/%0b", a, al, e, el); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range("overflow", 12'd250, 8'd4, 8'd10, 8'd255, 8'd34);
    test_range("underflow", 12'd0, 8'd255, 8'h80, 8'd0, 8'd128);
    test_backpressure();
    test_busy_cfg();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_denorm.md
LAYER_DENORM -- requirements
Module: layer_denorm

Interface
REQ-001 SHALL have parameter N, default 4, meaning elements per vector (N >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  vector parameters offered.
REQ-006 SHALL have port cfg_ready  output  1  block can accept parameters.
REQ-007 SHALL have port cfg_mean  input  DATA_WIDTH+4  unsigned vector mean.
REQ-008 SHALL have port cfg_scale  input  DATA_WIDTH  unsigned scale factor.
REQ-009 SHALL have port in_valid  input  1  normalized element offered.
REQ-010 SHALL have port in_ready  output  1  block can accept an element.
REQ-011 SHALL have port in_data  input  DATA_WIDTH  signed two's-complement normalized element.
REQ-012 SHALL have port out_valid  output  1  reconstructed element available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  unsigned reconstructed element.
REQ-015 SHALL have port out_last  output  1  qualifies the N-th element of a vector.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last element is consumed.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-018 IDLE: cfg_ready=1, in_ready=0. On cfg_valid, SHALL latch cfg_mean and cfg_scale, clear the element counter and enter RUN.
REQ-019 RUN: cfg_ready=0, in_ready = !out_valid || out_ready. A handshake is in_valid && in_ready.
REQ-020 SHALL compute each element as in_data (sign-extended) * cfg_scale (zero-extended) + cfg_mean (zero-extended), at signed 2*DATA_WIDTH+6 bits with no intermediate overflow.
REQ-021 The result SHALL be registered, with out_valid=1 on the cycle after the input handshake (latency 1 cycle).
REQ-022 Throughput SHALL be one element per cycle while out_ready=1.
REQ-023 Same-cycle output pop and input push SHALL both complete, with no bubble.
REQ-024 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on a pop with no new push.
REQ-026 out_last SHALL be 1 exactly for the element accepted when counter == N-1.
REQ-027 After the N-th handshake, the FSM SHALL enter FLUSH with in_ready=0.
REQ-028 FLUSH: on the pop of the last element, the FSM SHALL enter IDLE and pulse done=1 on the following cycle only.
REQ-029 cfg_valid outside IDLE SHALL be ignored; latched parameters SHALL remain unchanged.
REQ-030 in_valid in IDLE or FLUSH SHALL be ignored and no element consumed.
REQ-031 For N=1, the first handshake SHALL set out_last and enter FLUSH directly.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set: state IDLE, counter 0, out_valid 0, out_last 0, out_data 0, done 0, latched mean 0, latched scale 0.
REQ-033 Reset mid-vector SHALL discard any in-flight element; no done pulse SHALL be produced for that vector.
REQ-034 cfg_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-035 With macro LAYER_DENORM_SAT_EN defined, a result below 0 SHALL clamp to 0 and a result above 2^DATA_WIDTH-1 SHALL clamp to 2^DATA_WIDTH-1.
REQ-036 Without LAYER_DENORM_SAT_EN, out_data SHALL be the low DATA_WIDTH bits of the full result (wrap-around).
REQ-037 In-range results SHALL be identical with and without LAYER_DENORM_SAT_EN.

Verification
REQ-038 Basic vector: mean=100, scale=2, in {-3,0,5,10}, out_ready=1 -> out {94,100,110,120}; out_last on 120; done pulse 1 cycle after the last pop; 4 consecutive out_valid cycles.
REQ-039 Overflow: mean=250, scale=4, in=10 -> out 255 with LAYER_DENORM_SAT_EN, 34 without.
REQ-040 Underflow: mean=0, scale=255, in=-128 -> out 0 with LAYER_DENORM_SAT_EN, 128 without.
REQ-041 Backpressure: out_ready=0 for 3 cycles mid-vector -> out_data held, in_ready=0, no element lost or duplicated; order preserved.
REQ-042 Busy config: cfg_valid with mean=7 during RUN -> ignored; remaining outputs use the original mean; cfg_ready=0.
REQ-043 Reset: rst pulse after 2 of 4 elements -> out_valid=0 next cycle, no done, cfg_ready=1; a new vector then processes correctly.
